// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants for the PS/2 WASD key tracker: direction encoding,
// scan-code prefixes, device-response bytes and parser state encoding.
package ps2_key_tracker_pkg;

    // Direction encoding shared with get_direction / movement_FSM.
    localparam logic [2:0] DIR_STILL = 3'b000;
    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_DOWN  = 3'b011;
    localparam logic [2:0] DIR_RIGHT = 3'b100;

    // Set-2 prefix bytes.
    localparam logic [7:0] PREFIX_E0 = 8'hE0;
    localparam logic [7:0] PREFIX_F0 = 8'hF0;

    // Parser states.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRE_E0   = 2'd1;
    localparam logic [1:0] ST_PRE_F0   = 2'd2;
    localparam logic [1:0] ST_PRE_E0F0 = 2'd3;

    // Bytes the keyboard sends as command responses rather than key codes.
    function automatic logic is_device_response(input logic [7:0] code);
        logic resp;
        case (code)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: resp = 1'b1;
            default:                                  resp = 1'b0;
        endcase
        return resp;
    endfunction

    // Map a one-hot held-key vector (bit0=W .. bit3=D) to a direction.
    function automatic logic [2:0] onehot_to_dir(input logic [3:0] hit);
        logic [2:0] dir;
        case (hit)
            4'b0001: dir = DIR_UP;
            4'b0010: dir = DIR_LEFT;
            4'b0100: dir = DIR_DOWN;
            4'b1000: dir = DIR_RIGHT;
            default: dir = DIR_STILL;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_prefix_timer.sv
// Prefix timeout counter: counts while enabled, restarts on clear, and
// flags the cycle in which the count sits at its terminal value.
module ps2_prefix_timer #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Count up while a prefix is pending; hold at the terminal value.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= {CW{1'b0}};
        end else if (clear || !enable) begin
            count_r <= {CW{1'b0}};
        end else if (count_r != LAST_COUNT) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = enable && !clear && (count_r == LAST_COUNT);

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 parser that tracks held W/A/S/D keys and reports the most
// recently pressed key that is still held as a registered direction.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter logic [7:0] W_CODE         = 8'h1D,
    parameter logic [7:0] A_CODE         = 8'h1C,
    parameter logic [7:0] S_CODE         = 8'h1B,
    parameter logic [7:0] D_CODE         = 8'h23,
    parameter int         TIMEOUT_CYCLES = 2500000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_data_en,
    output logic [3:0] key_held,
    output logic [2:0] direction,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       timeout_pulse
);

    logic [1:0] state_r;
    logic [3:0] key_held_r;
    logic [2:0] direction_r;
    logic       make_r;
    logic       break_r;
    logic [7:0] key_code_r;
    logic       key_ext_r;
    logic       timeout_r;

    logic [1:0] state_nx_s;
    logic       do_make_s;
    logic       do_break_s;
    logic       ev_ext_s;
    logic       timeout_nx_s;
    logic       timer_clear_s;
    logic       timer_expire_s;
    logic [3:0] wasd_hit_s;
    logic [3:0] held_nx_s;
    logic [2:0] dir_nx_s;
    logic [7:0] code_nx_s;
    logic       ext_nx_s;

    ps2_prefix_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_prefix_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (timer_clear_s),
        .enable (state_r != ST_IDLE),
        .expire (timer_expire_s)
    );

    assign wasd_hit_s = {ps2_data == D_CODE, ps2_data == S_CODE,
                         ps2_data == A_CODE, ps2_data == W_CODE};

    // Byte parser: decide next prefix state and which event (if any) fires.
    always_comb begin
        state_nx_s    = state_r;
        do_make_s     = 1'b0;
        do_break_s    = 1'b0;
        ev_ext_s      = 1'b0;
        timeout_nx_s  = 1'b0;
        timer_clear_s = 1'b0;
        if (ps2_data_en) begin
            if (ps2_data == PREFIX_E0) begin
                // E0 always (re)starts an extended sequence.
                state_nx_s    = ST_PRE_E0;
                timer_clear_s = 1'b1;
            end else if (ps2_data == PREFIX_F0) begin
                state_nx_s    = (state_r == ST_PRE_E0) ? ST_PRE_E0F0 : ST_PRE_F0;
                timer_clear_s = 1'b1;
            end else begin
                state_nx_s = ST_IDLE;
                case (state_r)
                    ST_IDLE: begin
                        do_make_s = !is_device_response(ps2_data);
                    end
                    ST_PRE_E0: begin
                        do_make_s = 1'b1;
                        ev_ext_s  = 1'b1;
                    end
                    ST_PRE_F0: begin
                        do_break_s = 1'b1;
                    end
                    ST_PRE_E0F0: begin
                        do_break_s = 1'b1;
                        ev_ext_s   = 1'b1;
                    end
                    default: begin
                        do_make_s = 1'b0;
                    end
                endcase
            end
        end else if (timer_expire_s) begin
            // A byte in the expiry cycle takes precedence over the timeout.
            state_nx_s   = ST_IDLE;
            timeout_nx_s = 1'b1;
        end else begin
            state_nx_s = state_r;
        end
    end

    // Held-key and most-recent update; only non-extended events touch them.
    always_comb begin
        held_nx_s = key_held_r;
        dir_nx_s  = direction_r;
        code_nx_s = key_code_r;
        ext_nx_s  = key_ext_r;
        if (do_make_s) begin
            code_nx_s = ps2_data;
            ext_nx_s  = ev_ext_s;
            // Typematic repeats of an already-held key leave state alone.
            if (!ev_ext_s && ((wasd_hit_s & ~key_held_r) != 4'b0000)) begin
                held_nx_s = key_held_r | wasd_hit_s;
                dir_nx_s  = onehot_to_dir(wasd_hit_s);
            end else begin
                held_nx_s = key_held_r;
            end
        end else if (do_break_s) begin
            code_nx_s = ps2_data;
            ext_nx_s  = ev_ext_s;
            if (!ev_ext_s && ((wasd_hit_s & key_held_r) != 4'b0000)) begin
                held_nx_s = key_held_r & ~wasd_hit_s;
                // Releasing the active key falls back by W > A > S > D.
                if (direction_r == onehot_to_dir(wasd_hit_s)) begin
                    if (held_nx_s[0]) begin
                        dir_nx_s = DIR_UP;
                    end else if (held_nx_s[1]) begin
                        dir_nx_s = DIR_LEFT;
                    end else if (held_nx_s[2]) begin
                        dir_nx_s = DIR_DOWN;
                    end else if (held_nx_s[3]) begin
                        dir_nx_s = DIR_RIGHT;
                    end else begin
                        dir_nx_s = DIR_STILL;
                    end
                end else begin
                    dir_nx_s = direction_r;
                end
            end else begin
                held_nx_s = key_held_r;
            end
        end else begin
            held_nx_s = key_held_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            key_held_r  <= 4'b0000;
            direction_r <= DIR_STILL;
            make_r      <= 1'b0;
            break_r     <= 1'b0;
            key_code_r  <= 8'h00;
            key_ext_r   <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            key_held_r  <= held_nx_s;
            direction_r <= dir_nx_s;
            make_r      <= do_make_s;
            break_r     <= do_break_s;
            key_code_r  <= code_nx_s;
            key_ext_r   <= ext_nx_s;
            timeout_r   <= timeout_nx_s;
        end
    end

    assign key_held      = key_held_r;
    assign direction     = direction_r;
    assign make_pulse    = make_r;
    assign break_pulse   = break_r;
    assign key_code      = key_code_r;
    assign key_ext       = key_ext_r;
    assign timeout_pulse = timeout_r;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a behavioural model predicts each
// pulse event; a monitor compares whenever the DUT raises a pulse.
module tb_ps2_key_tracker;

    localparam int T = 16;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_data_en = 1'b0;
    logic [3:0] key_held;
    logic [2:0] direction;
    logic       make_pulse;
    logic       break_pulse;
    logic [7:0] key_code;
    logic       key_ext;
    logic       timeout_pulse;

    ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .resetn(resetn), .ps2_data(ps2_data),
        .ps2_data_en(ps2_data_en), .key_held(key_held), .direction(direction),
        .make_pulse(make_pulse), .break_pulse(break_pulse), .key_code(key_code),
        .key_ext(key_ext), .timeout_pulse(timeout_pulse)
    );

    always #5 clock = ~clock;

    int ecnt = 0;
    always @(posedge clock) ecnt++;

    typedef struct {
        int       cyc;
        bit [2:0] kind;   // {timeout, break, make}
        bit [7:0] code;
        bit       ext;
        bit [3:0] held;
        bit [2:0] dir;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: pending prefix, cycles waited, held set, most recent.
    int       pfx = 0;      // 0 none, 1 E0, 2 F0, 3 E0 F0
    int       idle_n = 0;
    bit [3:0] m_held = 4'b0000;
    int       m_recent = -1;

    function automatic int key_of(bit [7:0] b);
        if (b == 8'h1D) return 0;
        if (b == 8'h1C) return 1;
        if (b == 8'h1B) return 2;
        if (b == 8'h23) return 3;
        return -1;
    endfunction

    function automatic bit is_resp(bit [7:0] b);
        return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
    endfunction

    function automatic bit [2:0] m_dir();
        return (m_recent < 0) ? 3'd0 : 3'(m_recent + 1);
    endfunction

    task automatic push(bit [2:0] kind, bit [7:0] code, bit ext);
        ev_t e;
        e.cyc = ecnt + 1; e.kind = kind; e.code = code; e.ext = ext;
        e.held = m_held; e.dir = m_dir();
        q.push_back(e);
    endtask

    task automatic model_make(bit [7:0] b, bit ext);
        int k = key_of(b);
        if (!ext && k >= 0 && !m_held[k]) begin
            m_held[k] = 1'b1;
            m_recent = k;
        end
        push(3'b001, b, ext);
    endtask

    task automatic model_break(bit [7:0] b, bit ext);
        int k = key_of(b);
        if (!ext && k >= 0 && m_held[k]) begin
            m_held[k] = 1'b0;
            if (m_recent == k) begin
                m_recent = -1;
                for (int i = 3; i >= 0; i--) if (m_held[i]) m_recent = i;
            end
        end
        push(3'b010, b, ext);
    endtask

    task automatic model_step(bit en, bit [7:0] b);
        if (!en) begin
            if (pfx != 0) begin
                idle_n++;
                if (idle_n == T) begin
                    pfx = 0;
                    push(3'b100, 8'h00, 1'b0);
                end
            end
        end else if (b == 8'hE0) begin
            pfx = 1; idle_n = 0;
        end else if (b == 8'hF0) begin
            pfx = (pfx == 1) ? 3 : 2; idle_n = 0;
        end else begin
            case (pfx)
                0: if (!is_resp(b)) model_make(b, 1'b0);
                1: model_make(b, 1'b1);
                2: model_break(b, 1'b0);
                default: model_break(b, 1'b1);
            endcase
            pfx = 0;
        end
    endtask

    task automatic model_reset();
        pfx = 0; idle_n = 0; m_held = 4'b0000; m_recent = -1;
    endtask

    task automatic step(bit en, bit [7:0] b);
        @(negedge clock);
        ps2_data_en = en;
        ps2_data = en ? b : 8'($urandom);
        model_step(en, b);
    endtask

    task automatic send(bit [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic check_reset();
        checks++;
        if ({key_held, direction, make_pulse, break_pulse, key_code, key_ext, timeout_pulse} != 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: held=%b dir=%b mk=%b brk=%b code=%h ext=%b tmo=%b, required all 0",
                     key_held, direction, make_pulse, break_pulse, key_code, key_ext, timeout_pulse);
        end
    endtask

    // Monitor: pop and compare on every pulse; flag expected pulses that never came.
    ev_t me;
    always @(posedge clock) begin
        #1;
        if (resetn) begin
            if (make_pulse || break_pulse || timeout_pulse) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: cyc=%0d mk=%b brk=%b tmo=%b code=%h, required none",
                             ecnt, make_pulse, break_pulse, timeout_pulse, key_code);
                end else begin
                    me = q.pop_front();
                    if (ecnt != me.cyc || {timeout_pulse, break_pulse, make_pulse} != me.kind ||
                        key_held != me.held || direction != me.dir ||
                        (me.kind != 3'b100 && (key_code != me.code || key_ext != me.ext))) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d kind=%b code=%h ext=%b held=%b dir=%b, required cyc=%0d kind=%b code=%h ext=%b held=%b dir=%b",
                                 ecnt, {timeout_pulse, break_pulse, make_pulse}, key_code, key_ext, key_held, direction,
                                 me.cyc, me.kind, me.code, me.ext, me.held, me.dir);
                    end
                end
            end else if (q.size() != 0 && q[0].cyc <= ecnt) begin
                me = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: cyc=%0d no pulse, required kind=%b code=%h", ecnt, me.kind, me.code);
            end
        end
    end

    bit [7:0] keys [4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
    bit [7:0] resps[6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    initial begin
        int r;
        repeat (3) @(negedge clock);
        check_reset();
        resetn = 1'b1;
        model_reset();

        // Single W make.
        send(8'h1D); idle(2);
        // D on top of W, release D falls back to W, then release W.
        send(8'h23); send(8'hF0); send(8'h23); idle(1);
        send(8'hF0); send(8'h1D); idle(1);
        // Typematic A, then S, release S, release A.
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'h1B);
        send(8'hF0); send(8'h1B); send(8'hF0); send(8'h1C); idle(2);
        // Extended make/break of 1D must not touch W.
        send(8'hE0); send(8'h1D); send(8'hE0); send(8'hF0); send(8'h1D); idle(2);
        // Timeout after F0, then a plain make.
        send(8'hF0); idle(T + 2); send(8'h1D); idle(1);
        // Byte lands in the expiry cycle: byte wins.
        send(8'hF0); idle(T - 1); send(8'h1D); idle(1);
        // Timeout after E0 and after E0 F0; prefix restarts.
        send(8'hE0); idle(T + 1); send(8'hE0); send(8'hF0); idle(T + 1);
        send(8'hF0); send(8'hE0); send(8'h1C); send(8'hF0); send(8'hF0); send(8'h1C); idle(1);
        // Device responses in idle are silent.
        for (int i = 0; i < 6; i++) send(resps[i]);
        idle(2);
        // Reset mid-sequence with W and D held.
        send(8'h1D); send(8'h23); send(8'hF0); idle(1);
        @(negedge clock);
        ps2_data_en = 1'b0;
        resetn = 1'b0;
        model_reset();
        @(negedge clock); check_reset();
        @(negedge clock); check_reset();
        resetn = 1'b1;
        send(8'h23); idle(3);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      send(keys[$urandom_range(0, 3)]);
            else if (r < 58) send(8'hF0);
            else if (r < 66) send(8'hE0);
            else if (r < 71) send(resps[$urandom_range(0, 5)]);
            else if (r < 80) send(8'($urandom_range(0, 255)));
            else if (r < 96) idle($urandom_range(1, 3));
            else             idle($urandom_range(T - 2, T + 2));
        end
        idle(T + 4);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d events outstanding, required 0", q.size());
        end
        checks++;
        if (key_held != m_held || direction != m_dir()) begin
            errors++;
            $display("FAIL final_state: held=%b dir=%b, required held=%b dir=%b",
                     key_held, direction, m_held, m_dir());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits between PS2_Controller (received_data / received_data_en) and the WASD direction/movement logic.
- Parses the PS/2 set-2 byte stream, including E0 (extended) and F0 (break) prefixes, and keeps live held-state for W/A/S/D.
- Outputs a registered 3-bit direction: the most recently pressed WASD key that is still held.
- Replaces sampling the raw last byte on a slow enable, so key releases and typematic repeats are handled correctly.

Parameters:
- W_CODE, 8'h1D, make code for up
- A_CODE, 8'h1C, make code for left
- S_CODE, 8'h1B, make code for down
- D_CODE, 8'h23, make code for right
- TIMEOUT_CYCLES, 2500000, clock cycles a prefix may wait for its next byte (50 ms at 50 MHz)

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous, active-low reset
- ps2_data  in  8  byte from PS2_Controller
- ps2_data_en  in  1  one-cycle strobe; ps2_data valid this cycle
- key_held  out  4  bit0=W, bit1=A, bit2=S, bit3=D; 1 while held
- direction  out  3  000 still, 001 up, 010 left, 011 down, 100 right
- make_pulse  out  1  one-cycle pulse on any make, non-extended or extended
- break_pulse  out  1  one-cycle pulse on any break
- key_code  out  8  code of last make/break event
- key_ext  out  1  1 if last event was E0-extended
- timeout_pulse  out  1  one-cycle pulse when a pending prefix is discarded

Behaviour:
- Reset is asynchronous, active-low. While resetn=0:
  - all outputs are 0; direction=000
  - FSM is in IDLE; timeout counter is 0; priority register is cleared.
- All outputs are registered. An event strobed at cycle N is visible at cycle N+1. Pulses are high for exactly one cycle.
- Bytes are consumed only when ps2_data_en=1. ps2_data is ignored otherwise.
- FSM states: IDLE, PRE_E0, PRE_F0, PRE_E0F0.
- IDLE:
  - E0 -> PRE_E0.
  - F0 -> PRE_F0.
  - FA, AA, EE, FE, 00, FF are device responses: ignored, no pulse, stay in IDLE.
  - Any other byte is a non-extended make: make_pulse=1, key_code=byte, key_ext=0.
- PRE_E0:
  - F0 -> PRE_E0F0.
  - Any other byte is an extended make: make_pulse=1, key_ext=1, -> IDLE. key_held is unaffected.
- PRE_F0: any byte is a non-extended break: break_pulse=1, key_code=byte, key_ext=0, -> IDLE.
- PRE_E0F0: any byte is an extended break: break_pulse=1, key_ext=1, -> IDLE. key_held is unaffected.
- Only non-extended events change key_held. Extended E0 1D (right-ctrl) must not set W.
- WASD make:
  - If the key's bit was 0: set it and record the key as most recent.
  - If the bit was already 1 (typematic repeat): make_pulse still fires, but key_held and the most-recent record are unchanged.
- WASD break:
  - Clear the key's bit.
  - If it was the most-recent key, most-recent falls back to the remaining held keys by fixed priority W > A > S > D.
  - If none remain, most-recent is cleared.
- Break of a key that is not held: break_pulse fires; no other change.
- direction is the encoding of the most-recent key, or 000 when no WASD key is held. It updates in the same cycle as key_held.
- Timeout:
  - In any PRE_* state the counter increments every cycle; it is cleared on entry to a PRE_* state.
  - When the count reaches TIMEOUT_CYCLES-1 with no strobe: timeout_pulse=1, -> IDLE, prefix discarded.
  - If ps2_data_en=1 in that same cycle, the byte wins: it is processed normally and there is no timeout_pulse.
- E0 or F0 received while in a PRE_* state: F0 in PRE_E0 is handled as above. Otherwise the new prefix restarts parsing: E0 -> PRE_E0, F0 in PRE_F0/PRE_E0F0 -> PRE_F0, and the timeout counter clears.
- Reset asserted mid-sequence (e.g. after F0) leaves no residue: the next byte is parsed from IDLE.

Decomposition:
- Shared package holds:
  - the direction encoding (DIR_STILL..DIR_RIGHT, also used by get_direction/movement_FSM)
  - prefix constants E0/F0
  - the device-response byte list
  - the FSM state enumeration
- One natural sub-module: ps2_prefix_timer, a counter with clear and terminal pulse, parameterised by TIMEOUT_CYCLES (bench uses a small value, e.g. 16).
- Priority fallback stays inline.

Test Plan:
- Strobe 1D -> next cycle key_held=0001, direction=001, make_pulse=1, key_ext=0.
- Strobe 1D, 23, then F0 23 -> direction 001, then 100, then back to 001; key_held goes 0001, 1001, 0001.
- Strobe 1C three times (typematic), then 1B -> make_pulse three times, direction 010 then 011; then F0 1B -> direction 010.
- Strobe E0 1D, then E0 F0 1D -> two pulses with key_ext=1; key_held stays 0000, direction stays 000.
- With TIMEOUT_CYCLES=16: strobe F0, idle 16 cycles -> timeout_pulse at cycle 15 after entry; then 1D -> treated as make, key_held=0001.
- Hold W and D, strobe F0, assert resetn=0 for 2 cycles, release, strobe 23 -> all cleared during reset; afterwards key_held=1000, direction=100, make_pulse=1, no break_pulse.
